// File: rtl/layer_input_sequencer.sv
// layer_input_sequencer: buffers host vectors and streams them into the cell chain.
// Optional DRAIN watchdog with `define SEQ_TIMEOUT_EN (adds port timeout).
module layer_input_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_AMOUNT = 4,
  parameter int MAX_VECTORS   = 4
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_enable,
  input  logic [DATA_WIDTH-1:0]            wr_value,
  input  logic                             start,
  input  logic [$clog2(MAX_VECTORS+1)-1:0] vector_count,
  output logic [DATA_WIDTH-1:0]            output_index,
  output logic [DATA_WIDTH-1:0]            output_value,
  output logic                             output_enable,
  input  logic [DATA_WIDTH:0]              input_result,
  output logic [DATA_WIDTH-1:0]            result_value,
  output logic                             result_valid,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow,
  output logic                             start_error
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic                             timeout
`endif
);

  localparam int DEPTH = WEIGHT_AMOUNT * MAX_VECTORS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(MAX_VECTORS + 1);
  localparam int IW    = (WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         total_q;
  logic [IW-1:0]         bidx_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         res_cnt_q;

  logic [PW-1:0]         wr_ptr_d;
  logic                  wr_hit;
  logic                  wr_ok;
  logic                  start_ok;
  logic                  res_hit;
  logic [31:0]           need;
  logic [DATA_WIDTH-1:0] first_val;

`ifdef SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q;
`endif

  always_comb begin
    wr_hit   = (state_q == S_IDLE) && wr_enable;
    wr_ok    = wr_hit && (wr_ptr_q < PW'(DEPTH));
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    need     = 32'(vector_count) * 32'(WEIGHT_AMOUNT);
    // a write in the start cycle counts toward the load check
    start_ok = (vector_count != '0)
            && (32'(vector_count) <= 32'(MAX_VECTORS))
            && (need <= 32'(wr_ptr_d));
    first_val = (wr_ok && wr_ptr_q == '0) ? wr_value : mem_q[0];
    res_hit  = input_result[DATA_WIDTH]
            && (state_q == S_STREAM || state_q == S_DRAIN)
            && (res_cnt_q != cnt_q);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      total_q       <= '0;
      bidx_q        <= '0;
      cnt_q         <= '0;
      res_cnt_q     <= '0;
      output_index  <= '0;
      output_value  <= '0;
      output_enable <= 1'b0;
      result_value  <= '0;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      start_error   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_q          <= '0;
      timeout       <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      start_error  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
      if (res_hit) begin
        result_value <= input_result[DATA_WIDTH-1:0];
        result_valid <= 1'b1;
        res_cnt_q    <= res_cnt_q + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          wr_ptr_q <= wr_ptr_d;
          if (wr_hit && !wr_ok) overflow <= 1'b1;
          if (start) begin
            if (start_ok) begin
              state_q       <= S_STREAM;
              cnt_q         <= vector_count;
              total_q       <= PW'(need);
              res_cnt_q     <= '0;
              overflow      <= 1'b0;
              busy          <= 1'b1;
              // first beat leaves on the accepting edge
              output_enable <= 1'b1;
              output_index  <= '0;
              output_value  <= first_val;
              rd_ptr_q      <= PW'(1);
              bidx_q        <= (WEIGHT_AMOUNT > 1) ? IW'(1) : '0;
            end else begin
              start_error <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (rd_ptr_q == total_q) begin
            state_q       <= S_DRAIN;
            output_enable <= 1'b0;
            output_index  <= '0;
            output_value  <= '0;
`ifdef SEQ_TIMEOUT_EN
            wd_q          <= '0;
`endif
          end else begin
            output_enable <= 1'b1;
            output_index  <= DATA_WIDTH'(bidx_q);
            output_value  <= mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_q      <= rd_ptr_q + 1'b1;
            bidx_q        <= (bidx_q == IW'(WEIGHT_AMOUNT - 1)) ?
                             '0 : bidx_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (res_cnt_q == cnt_q) begin
            state_q <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (res_hit) begin
            wd_q <= '0;
          end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_input_sequencer.sv
// tb_layer_input_sequencer: randomized scoreboard bench for layer_input_sequencer.
// A queue-based model predicts beats, results, done and start_error cycles.
module tb_layer_input_sequencer;
  localparam int DW    = 32;
  localparam int WA    = 4;
  localparam int MV    = 4;
  localparam int DEPTH = WA * MV;
  localparam int CW    = $clog2(MV + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_enable = 1'b0;
  logic [DW-1:0] wr_value = '0;
  logic          start = 1'b0;
  logic [CW-1:0] vector_count = '0;
  logic [DW-1:0] output_index;
  logic [DW-1:0] output_value;
  logic          output_enable;
  logic [DW:0]   input_result = '0;
  logic [DW-1:0] result_value;
  logic          result_valid;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          start_error;
`ifdef SEQ_TIMEOUT_EN
  logic          timeout;
`endif

  always #5 clk = ~clk;

  layer_input_sequencer #(
    .DATA_WIDTH    (DW),
    .WEIGHT_AMOUNT (WA),
    .MAX_VECTORS   (MV)
`ifdef SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_enable    (wr_enable),
    .wr_value     (wr_value),
    .start        (start),
    .vector_count (vector_count),
    .output_index (output_index),
    .output_value (output_value),
    .output_enable(output_enable),
    .input_result (input_result),
    .result_value (result_value),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .start_error  (start_error)
`ifdef SEQ_TIMEOUT_EN
    ,
    .timeout      (timeout)
`endif
  );

  typedef struct {
    int            c;
    logic [DW-1:0] i;
    logic [DW-1:0] v;
  } beat_t;

  typedef struct {
    int            c;
    logic [DW-1:0] v;
  } res_t;

  beat_t bq[$];
  res_t  rq[$];
  int    dq[$];
  int    sq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [DW-1:0] mbuf [DEPTH];
  int            wcnt = 0;
  bit            ovf  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
  endtask

  beat_t mb;
  res_t  mr;
  int    md;

  always @(negedge clk) begin
    if (!rst) begin
      if (output_enable) begin
        if (bq.size() == 0) begin
          chk("beat_unexpected", 64'(output_enable), 64'(0));
        end else begin
          mb = bq.pop_front();
          chk("beat_cyc", 64'(cyc), 64'(mb.c));
          chk("beat_idx", 64'(output_index), 64'(mb.i));
          chk("beat_val", 64'(output_value), 64'(mb.v));
          chk("beat_busy", 64'(busy), 64'(1));
        end
      end else begin
        chk("stream_idle_zero", {output_index, output_value}, 64'(0));
      end
      if (result_valid) begin
        if (rq.size() == 0) begin
          chk("res_unexpected", 64'(result_valid), 64'(0));
        end else begin
          mr = rq.pop_front();
          chk("res_cyc", 64'(cyc), 64'(mr.c));
          chk("res_val", 64'(result_value), 64'(mr.v));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 64'(done), 64'(0));
        end else begin
          md = dq.pop_front();
          chk("done_cyc", 64'(cyc), 64'(md));
          chk("done_busy", 64'(busy), 64'(0));
        end
      end
      if (start_error) begin
        if (sq.size() == 0) begin
          chk("serr_unexpected", 64'(start_error), 64'(0));
        end else begin
          md = sq.pop_front();
          chk("serr_cyc", 64'(cyc), 64'(md));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [DW-1:0] v);
    if (wcnt < DEPTH) begin
      mbuf[wcnt] = v;
      wcnt++;
    end else begin
      ovf = 1'b1;
    end
  endtask

  task automatic wr(input logic [DW-1:0] v);
    wr_enable = 1'b1;
    wr_value  = v;
    model_write(v);
    tick();
    wr_enable = 1'b0;
  endtask

  task automatic start_run(input int vc, input bit cw, input logic [DW-1:0] cv,
                           input int ntok, input bit fix,
                           input logic [DW-1:0] fv);
    int            n0;
    int            total;
    int            off;
    int            rlast;
    int            dcyc;
    int            last;
    int            offs[$];
    logic [DW-1:0] vals[$];
    bit            acc;
    beat_t         nb;
    res_t          nr;
    n0 = cyc;
    if (cw) model_write(cv);
    wr_enable    = cw;
    wr_value     = cv;
    start        = 1'b1;
    vector_count = CW'(vc);
    acc = (vc >= 1) && (vc <= MV) && (vc * WA <= wcnt);
    if (!acc) begin
      sq.push_back(n0 + 1);
      tick();
      start     = 1'b0;
      wr_enable = 1'b0;
      return;
    end
    ovf   = 1'b0;
    total = vc * WA;
    for (int k = 0; k < total; k++) begin
      nb = '{n0 + 1 + k, DW'(k % WA), mbuf[k]};
      bq.push_back(nb);
    end
    off   = 0;
    rlast = 0;
    for (int t = 0; t < ntok; t++) begin
      off += $urandom_range(1, 6);
      offs.push_back(off);
      vals.push_back(fix ? fv : DW'($urandom));
      if (t < vc) begin
        nr = '{n0 + off + 1, vals[t]};
        rq.push_back(nr);
        rlast = n0 + off + 1;
      end
    end
    dcyc = (n0 + total + 2 > rlast + 1) ? n0 + total + 2 : rlast + 1;
    dq.push_back(dcyc);
    last = (dcyc > n0 + off) ? dcyc + 2 : n0 + off + 2;
    tick();
    start     = 1'b0;
    wr_enable = 1'b0;
    while (cyc < last) begin
      input_result = '0;
      foreach (offs[t]) if (n0 + offs[t] == cyc) input_result = {1'b1, vals[t]};
      if (cyc < dcyc) begin
        wr_enable    = 1'($urandom_range(0, 1));
        wr_value     = $urandom;
        start        = ($urandom_range(0, 3) == 0);
        vector_count = CW'($urandom_range(0, MV));
      end else begin
        wr_enable = 1'b0;
        start     = 1'b0;
      end
      tick();
    end
    input_result = '0;
    wr_enable    = 1'b0;
    start        = 1'b0;
    wcnt         = 0;
    @(negedge clk);
    chk("ovf_after_run", 64'(overflow), 64'(ovf));
    chk("busy_after_run", 64'(busy), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int n0;
    int nw;
    int vc;
    beat_t nb;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_index", 64'(output_index), 64'(0));
    chk("rst_value", 64'(output_value), 64'(0));
    chk("rst_enable", 64'(output_enable), 64'(0));
    chk("rst_result", 64'(result_value), 64'(0));
    chk("rst_rvalid", 64'(result_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_serr", 64'(start_error), 64'(0));
`ifdef SEQ_TIMEOUT_EN
    chk("rst_timeout", 64'(timeout), 64'(0));
`endif
    tick();

    // normal run
    for (int i = 0; i < 8; i++) wr((i < 4) ? 32'd1 : 32'd2);
    start_run(2, 1'b0, '0, 2, 1'b1, 32'd3);

    // rejected starts, then the same load streamed
    for (int i = 0; i < 4; i++) wr($urandom);
    start_run(2, 1'b0, '0, 2, 1'b0, '0);
    start_run(0, 1'b0, '0, 0, 1'b0, '0);
    repeat (2) tick();
    start_run(1, 1'b0, '0, 1, 1'b0, '0);

    // overflow
    for (int i = 0; i < 17; i++) wr($urandom);
    @(negedge clk);
    chk("overflow_set", 64'(overflow), 64'(1));
    tick();
    start_run(4, 1'b0, '0, 4, 1'b0, '0);

    // write in the start cycle
    for (int i = 0; i < 7; i++) wr($urandom);
    start_run(2, 1'b1, $urandom, 2, 1'b0, '0);

    // stray token in IDLE, then excess tokens
    input_result = {1'b1, 32'd5};
    tick();
    input_result = '0;
    @(negedge clk);
    chk("idle_token", 64'(result_valid), 64'(0));
    tick();
    for (int i = 0; i < 8; i++) wr($urandom);
    start_run(2, 1'b0, '0, 3, 1'b0, '0);

    // mid-stream reset at beat 3
    for (int i = 0; i < 8; i++) wr($urandom);
    n0 = cyc;
    start = 1'b1;
    vector_count = CW'(2);
    for (int k = 0; k < 4; k++) begin
      nb = '{n0 + 1 + k, DW'(k % WA), mbuf[k]};
      bq.push_back(nb);
    end
    tick();
    start = 1'b0;
    while (cyc < n0 + 4) tick();
    @(negedge clk);
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    wcnt = 0;
    ovf  = 1'b0;
    @(negedge clk);
    chk("mrst_enable", 64'(output_enable), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_done", 64'(done), 64'(0));
    tick();
    for (int i = 0; i < 4; i++) wr($urandom);
    start_run(1, 1'b0, '0, 1, 1'b0, '0);

`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 4; i++) wr($urandom);
    n0 = cyc;
    start = 1'b1;
    vector_count = CW'(1);
    for (int k = 0; k < 4; k++) begin
      nb = '{n0 + 1 + k, DW'(k), mbuf[k]};
      bq.push_back(nb);
    end
    dq.push_back(n0 + 13);
    tick();
    start = 1'b0;
    while (cyc < n0 + 13) tick();
    @(negedge clk);
    chk("timeout_set", 64'(timeout), 64'(1));
    chk("timeout_done", 64'(done), 64'(1));
    tick();
    wcnt = 0;
    ovf  = 1'b0;
    @(negedge clk);
    chk("timeout_pulse", 64'(timeout), 64'(0));
    tick();
`endif

    // randomized runs
    for (int it = 0; it < 14; it++) begin
      nw = $urandom_range(0, 10);
      vc = $urandom_range(0, 5);
      repeat (nw) wr($urandom);
      start_run(vc, 1'($urandom_range(0, 1)), $urandom,
                vc + $urandom_range(0, 2), 1'b0, '0);
      tick();
    end

    repeat (4) tick();
    chk("beat_q_empty", 64'(bq.size()), 64'(0));
    chk("res_q_empty", 64'(rq.size()), 64'(0));
    chk("done_q_empty", 64'(dq.size()), 64'(0));
    chk("serr_q_empty", 64'(sq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_input_sequencer.md
Name: layer_input_sequencer

Overview:
Front-end controller for a chain of weight_comp_cell stages. The host preloads input vectors into a local buffer and pulses start. The block then streams WEIGHT_AMOUNT (index, value, enable) beats per vector into the first cell, with no bubbles. It collects the classification tokens returned by softmax_cell and signals done once every vector has produced a result.

Parameters:
DATA_WIDTH, 32, width of values and results
WEIGHT_AMOUNT, 4, beats per vector; index runs 0..WEIGHT_AMOUNT-1
MAX_VECTORS, 4, buffer capacity in vectors; DEPTH = WEIGHT_AMOUNT*MAX_VECTORS
TIMEOUT_CYCLES, 1024, drain watchdog limit (used only with SEQ_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_enable  in  1  buffer write strobe
wr_value  in  DATA_WIDTH  value written at the current write pointer
start  in  1  one-cycle request to begin streaming
vector_count  in  clog2(MAX_VECTORS+1)  vectors to stream, sampled when start is accepted
output_index  out  DATA_WIDTH  to first cell input_index
output_value  out  DATA_WIDTH  to first cell input_value
output_enable  out  1  to first cell input_enable
input_result  in  DATA_WIDTH+1  from softmax_cell; MSB = valid, low bits = class
result_value  out  DATA_WIDTH  captured class
result_valid  out  1  one-cycle pulse per captured result
busy  out  1  high in STREAM and DRAIN
done  out  1  one-cycle completion pulse
overflow  out  1  sticky: a write was dropped because the buffer was full
start_error  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset: every output is 0, wr_ptr=0, rd_ptr=0, result counter=0, state IDLE. rst mid-operation aborts immediately; output_enable is low after that edge and buffer contents are don't-care.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE, writes:
  - wr_enable with wr_ptr<DEPTH stores wr_value at buf[wr_ptr] and increments wr_ptr.
  - wr_enable with wr_ptr==DEPTH drops the write and sets overflow.
  - wr_enable outside IDLE is ignored and does not set overflow.
- IDLE, start acceptance:
  - Start is accepted only if 1<=vector_count<=MAX_VECTORS and vector_count*WEIGHT_AMOUNT<=wr_ptr.
  - On acceptance: latch the count, clear rd_ptr, the result counter and overflow, then go to STREAM.
  - Otherwise pulse start_error for one cycle and stay in IDLE.
  - start in any state other than IDLE is ignored, with no error pulse.
- Same cycle start and wr_enable in IDLE: the write commits first, and the acceptance check uses the incremented wr_ptr.
- STREAM:
  - All stream outputs are registered. The first beat is driven the cycle after the start edge.
  - Each cycle: output_enable=1, output_index=rd_ptr mod WEIGHT_AMOUNT, output_value=buf[rd_ptr], then rd_ptr increments.
  - Exactly count*WEIGHT_AMOUNT contiguous beats, no bubbles. After the last beat go to DRAIN.
  - Outside STREAM, output_enable=0 and output_index=output_value=0.
- Result capture:
  - In STREAM or DRAIN, input_result[DATA_WIDTH]=1 registers result_value=input_result[DATA_WIDTH-1:0], pulses result_valid the next cycle, and increments the counter.
  - Valid tokens seen in IDLE or DONE are ignored.
  - Once the counter reaches the latched count, further tokens are ignored and the counter saturates.
- DRAIN: when the counter equals the latched count, go to DONE.
  - If the final result arrives during the last STREAM beat, still pass through DRAIN for one cycle.
- DONE: done=1 for one cycle, busy=0, wr_ptr cleared to 0 so the buffer is ready for a fresh load. Next state IDLE.
- done is asserted no earlier than one cycle after the last result_valid pulse.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined:
  - Adds output port timeout (1 bit) and a DRAIN watchdog counter.
  - The watchdog clears on DRAIN entry and on each counted result.
  - If it reaches TIMEOUT_CYCLES, go to DONE; done and timeout pulse together for one cycle.
  - timeout is 0 at reset.
- Undefined: no port, no counter; DRAIN waits indefinitely for results.

Test Plan:
- Normal run:
  - Stimulus: write 1,1,1,1,2,2,2,2; vector_count=2; pulse start; return tokens 3 and 3.
  - Response: 8 consecutive beats starting 1 cycle after start, index 0,1,2,3,0,1,2,3, value 1x4 then 2x4, busy high throughout.
  - Each token gives a result_valid pulse with result_value=3. done pulses after the second token, then busy=0.
- Rejected start:
  - Stimulus: write 4 values; start with vector_count=2; then start with vector_count=0.
  - Response: start_error pulses each time, output_enable stays 0, state remains IDLE.
- Overflow:
  - Stimulus: with MAX_VECTORS=4, write 17 values.
  - Response: overflow=1 and wr_ptr=16. A subsequent accepted start with vector_count=4 clears overflow and streams 16 beats holding the first 16 values.
- Mid-stream reset:
  - Stimulus: assert rst at beat 3 of 8.
  - Response: the next cycle has output_enable=0, busy=0 and done=0. A following load plus start restarts at index 0.
- Stray and excess tokens:
  - Stimulus: a valid token while IDLE; 3 tokens with vector_count=2.
  - Response: the IDLE token gives no result_valid. Exactly 2 result_valid pulses, and one done.
- Timeout (SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: stream 1 vector, return no token.
  - Response: done and timeout pulse together 8 cycles after DRAIN entry.
